// File: rtl/nrisc_fetch_unit.sv
// nrisc_fetch_unit: PC, instruction fetch and IR stage of the 8-bit nRisc core
module nrisc_fetch_unit #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter logic [7:0] HALT_INSTR = 8'hFF,
    parameter int         CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             jump,
    input  logic [7:0]       jump_target,
    input  logic             branch,
    input  logic [7:0]       branch_off,
    input  logic [7:0]       instr,
    output logic [7:0]       Endereco,
    output logic [7:0]       ir,
    output logic [7:0]       ir_pc,
    output logic             ir_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d, ir_q, ir_d, ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d, halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State register; reset returns everything to its idle values immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state: jump beats a branch on a live IR, both beat stall, otherwise capture and advance
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                ir_valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (jump) begin
                    pc_d       = jump_target;
                    ir_valid_d = 1'b0;
                end else if (branch && ir_valid_q) begin
                    pc_d       = ir_pc_q + branch_off;
                    ir_valid_d = 1'b0;
                end else if (!stall) begin
                    ir_d       = instr;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (instr == HALT_INSTR) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            HALTED: ir_valid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    assign Endereco    = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_nrisc_fetch_unit.sv
// tb_nrisc_fetch_unit: table-driven check of fetch, redirects, stall, halt, reset and counter saturation
module tb_nrisc_fetch_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0;
    logic [7:0]  jump_target = 8'h00, branch_off = 8'h00;
    logic [7:0]  instr, Endereco, ir, ir_pc;
    logic        ir_valid, halted;
    logic [15:0] fetch_count;
    logic [7:0]  mem [256];

    logic        rst4_n = 1'b0, start4 = 1'b0, zero = 1'b0;
    logic [7:0]  zero8 = 8'h00;
    logic [7:0]  pc4, ir4, ir_pc4;
    logic        valid4, halted4;
    logic [3:0]  cnt4;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic        st, sl, jp;
        logic [7:0]  jt;
        logic        br;
        logic [7:0]  off, pc, ir, irpc;
        logic        v, h;
        logic [15:0] cnt;
    } vec_t;
    vec_t tab [$];

    always #5 clock = ~clock;
    assign instr = mem[Endereco];

    nrisc_fetch_unit dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stall(stall), .jump(jump),
        .jump_target(jump_target), .branch(branch), .branch_off(branch_off), .instr(instr),
        .Endereco(Endereco), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    nrisc_fetch_unit #(.CNT_W(4)) u4 (
        .clock(clock), .reset_n(rst4_n), .start(start4), .stall(zero), .jump(zero),
        .jump_target(zero8), .branch(zero), .branch_off(zero8), .instr(zero8),
        .Endereco(pc4), .ir(ir4), .ir_pc(ir_pc4), .ir_valid(valid4), .halted(halted4),
        .fetch_count(cnt4)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] pc, input logic [7:0] xir,
                           input logic [7:0] xirpc, input logic v, input logic h, input logic [15:0] c);
        chk({tag, " Endereco"}, {8'h00, Endereco}, {8'h00, pc});
        chk({tag, " ir"}, {8'h00, ir}, {8'h00, xir});
        chk({tag, " ir_pc"}, {8'h00, ir_pc}, {8'h00, xirpc});
        chk({tag, " ir_valid"}, {15'h0, ir_valid}, {15'h0, v});
        chk({tag, " halted"}, {15'h0, halted}, {15'h0, h});
        chk({tag, " fetch_count"}, fetch_count, c);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h13; mem[3] = 8'h14; mem[4] = 8'h15;
        mem[5] = 8'hFF; mem[8'h40] = 8'h5A;
        //           st sl jp jt     br off    pc     ir     irpc   v  h  cnt
        tab.push_back('{1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd0});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h11, 8'h00, 1, 0, 16'd1});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 8'h12, 8'h01, 1, 0, 16'd2});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h03, 8'h13, 8'h02, 1, 0, 16'd3});
        for (int k = 0; k < 4; k++)
            tab.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 8'h03, 8'h13, 8'h02, 1, 0, 16'd3});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 8'h14, 8'h03, 1, 0, 16'd4});
        tab.push_back('{0, 0, 1, 8'h02, 0, 8'h00, 8'h02, 8'h14, 8'h03, 0, 0, 16'd4});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h03, 8'h13, 8'h02, 1, 0, 16'd5});
        tab.push_back('{0, 1, 0, 8'h00, 1, 8'hFC, 8'hFE, 8'h13, 8'h02, 0, 0, 16'd5});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'hFE, 1, 0, 16'd6});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 0, 16'd7});
        tab.push_back('{0, 0, 1, 8'h40, 1, 8'h10, 8'h40, 8'h00, 8'hFF, 0, 0, 16'd7});
        tab.push_back('{0, 0, 0, 8'h00, 1, 8'h10, 8'h41, 8'h5A, 8'h40, 1, 0, 16'd8});
        tab.push_back('{0, 0, 1, 8'h05, 0, 8'h00, 8'h05, 8'h5A, 8'h40, 0, 0, 16'd8});
        tab.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h05, 8'hFF, 8'h05, 1, 1, 16'd9});
        tab.push_back('{1, 0, 1, 8'h20, 0, 8'h00, 8'h05, 8'hFF, 8'h05, 0, 1, 16'd9});
        tab.push_back('{0, 0, 0, 8'h00, 1, 8'h10, 8'h05, 8'hFF, 8'h05, 0, 1, 16'd9});

        #12;
        chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;
        rst4_n  = 1'b1;
        step();

        foreach (tab[i]) begin
            start = tab[i].st; stall = tab[i].sl; jump = tab[i].jp; jump_target = tab[i].jt;
            branch = tab[i].br; branch_off = tab[i].off;
            start4 = (i == 0);
            step();
            chk_all($sformatf("vec%0d", i), tab[i].pc, tab[i].ir, tab[i].irpc, tab[i].v, tab[i].h, tab[i].cnt);
            if (i == 10) chk("cnt4 at 10", {12'h0, cnt4}, 16'd10);
        end
        start = 0; stall = 0; jump = 0; branch = 0; start4 = 0;
        chk("cnt4 saturated", {12'h0, cnt4}, 16'h000F);

        #4 reset_n = 1'b0;
        #1 chk_all("async rst from halt", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;
        jump = 1; jump_target = 8'h33;
        step();
        chk_all("idle ignores jump", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        jump = 0; start = 1;
        step();
        start = 0; jump = 1; jump_target = 8'h37;
        step();
        jump = 0;
        chk_all("jump 37", 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        step();
        chk_all("fetch 37", 8'h38, 8'h00, 8'h37, 1'b1, 1'b0, 16'd1);
        #3 reset_n = 1'b0;
        #1 chk_all("async rst mid run", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;
        start = 1;
        step();
        start = 0;
        step();
        chk_all("restart", 8'h01, 8'h11, 8'h00, 1'b1, 1'b0, 16'd1);
        chk("cnt4 still saturated", {12'h0, cnt4}, 16'h000F);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
